// File: rtl/apu_frame_counter.sv
// APU frame sequencer: counts CPU cycles, emits quarter/half-frame clocks in
// 4-step or 5-step mode, and owns the frame IRQ flag driven to n_IRQ and $4015.
module apu_frame_counter #(
  parameter int STEP1   = 7457,
  parameter int STEP2   = 14913,
  parameter int STEP3   = 22371,
  parameter int PERIOD4 = 29830,
  parameter int PERIOD5 = 37282,
  parameter int CNT_W   = 16
) (
  input  logic       PHI1,
  input  logic       n_RES,
  input  logic       W4017,
  input  logic       n_R4015,
  input  logic [7:0] DB,
  output logic       QFRAME,
  output logic       HFRAME,
  output logic       IRQ_FLAG,
  output logic       n_IRQ
);

  localparam logic [CNT_W-1:0] LAST4 = CNT_W'(PERIOD4 - 1);
  localparam logic [CNT_W-1:0] LAST5 = CNT_W'(PERIOD5 - 1);
  localparam logic [CNT_W-1:0] PRE4  = CNT_W'(PERIOD4 - 2);
  localparam logic [3*CNT_W-1:0] STEP_VEC = {CNT_W'(STEP3), CNT_W'(STEP2), CNT_W'(STEP1)};
  localparam logic [2:0] HALF_MASK = 3'b010;

  logic [CNT_W-1:0] cyc_reg, cyc_next;
  logic             mode_reg, mode_next;
  logic             inhibit_reg, inhibit_next;
  logic             parity_reg, parity_next;
  logic             pending_reg, pending_next;
  logic [2:0]       delay_reg, delay_next;
  logic             wrap_irq_reg, wrap_irq_next;
  logic             irq_reg, irq_next;
  logic             qframe_reg, qframe_next;
  logic             hframe_reg, hframe_next;
  logic             n_irq_reg;

  logic [CNT_W-1:0] last_cyc;
  logic [2:0]       step_hit;
  logic             end_hit;
  logic             wrap;
  logic             reset_now;
  logic             irq_set;
  logic             irq_clr;
  logic             unused_db_bits;

  assign unused_db_bits = ^DB[5:0];

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_step
      assign step_hit[gi] = (cyc_reg == STEP_VEC[gi*CNT_W +: CNT_W]);
    end
  endgenerate

  assign last_cyc = mode_reg ? LAST5 : LAST4;
  assign end_hit  = (cyc_reg == last_cyc);
  // >= guards against a mode switch that leaves the count beyond the new period
  assign wrap     = (cyc_reg >= last_cyc);

  // A fresh write always restarts the delay, so it masks the final countdown edge
  assign reset_now = pending_reg && !W4017 && (delay_reg == 3'd1);

  assign irq_set = !mode_reg && !inhibit_reg &&
                   ((cyc_reg == PRE4) || (cyc_reg == LAST4) || wrap_irq_reg);
  assign irq_clr = !n_R4015 || (W4017 && DB[6]);

  always_comb begin
    parity_next   = ~parity_reg;
    mode_next     = mode_reg;
    inhibit_next  = inhibit_reg;
    pending_next  = pending_reg;
    delay_next    = delay_reg;
    cyc_next      = cyc_reg + CNT_W'(1);
    wrap_irq_next = 1'b0;

    if (W4017) begin
      mode_next    = DB[7];
      inhibit_next = DB[6];
      pending_next = 1'b1;
      delay_next   = parity_reg ? 3'd4 : 3'd3;
    end else if (pending_reg) begin
      delay_next = delay_reg - 3'd1;
      if (delay_reg == 3'd1) begin
        pending_next = 1'b0;
      end
    end

    if (reset_now || wrap) begin
      cyc_next = '0;
    end

    if (!reset_now && !mode_reg && end_hit) begin
      wrap_irq_next = 1'b1;
    end

    // Set beats clear when both land on the same edge
    irq_next = irq_set || (irq_reg && !irq_clr);

    qframe_next = (|step_hit) || end_hit || (reset_now && mode_reg);
    hframe_next = (|(step_hit & HALF_MASK)) || end_hit || (reset_now && mode_reg);
  end

  always_ff @(posedge PHI1 or negedge n_RES) begin
    if (!n_RES) begin
      cyc_reg      <= '0;
      mode_reg     <= 1'b0;
      inhibit_reg  <= 1'b0;
      parity_reg   <= 1'b0;
      pending_reg  <= 1'b0;
      delay_reg    <= 3'd0;
      wrap_irq_reg <= 1'b0;
      irq_reg      <= 1'b0;
      qframe_reg   <= 1'b0;
      hframe_reg   <= 1'b0;
      n_irq_reg    <= 1'b1;
    end else begin
      cyc_reg      <= cyc_next;
      mode_reg     <= mode_next;
      inhibit_reg  <= inhibit_next;
      parity_reg   <= parity_next;
      pending_reg  <= pending_next;
      delay_reg    <= delay_next;
      wrap_irq_reg <= wrap_irq_next;
      irq_reg      <= irq_next;
      qframe_reg   <= qframe_next;
      hframe_reg   <= hframe_next;
      n_irq_reg    <= ~irq_next;
    end
  end

  assign QFRAME   = qframe_reg;
  assign HFRAME   = hframe_reg;
  assign IRQ_FLAG = irq_reg;
  assign n_IRQ    = n_irq_reg;

endmodule
